// File: rtl/mem_wb_if.sv
// MEM/WB pipeline slot: one instruction's write-back payload plus its valid flag.
interface mem_wb_if;
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        llbit_we;
    logic        llbit_value;

    modport master (
        output valid, wd, wreg, wdata, whilo, hi, lo, llbit_we, llbit_value
    );

    modport slave (
        input  valid, wd, wreg, wdata, whilo, hi, lo, llbit_we, llbit_value
    );
endinterface

// File: rtl/mem_wb.sv
// MEM -> WB pipeline register with stall/flush handling and a retired-instruction counter.
module mem_wb #(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush,
    mem_wb_if.slave             mem,
    mem_wb_if.master            wb,
    output logic [RETIRE_W-1:0] retire_cnt
);

    logic        capture_c;
    logic        bubble_c;

    logic        valid_q;
    logic [4:0]  wd_q;
    logic        wreg_q;
    logic [31:0] wdata_q;
    logic        whilo_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        llbit_we_q;
    logic        llbit_value_q;
    logic [RETIRE_W-1:0] cnt_q;

    // Flush dominates; MEM held while WB runs inserts an empty slot.
    // Any other stall combination (including the illegal WB-only stall) holds.
    assign bubble_c  = flush | (stall[4] & ~stall[5]);
    assign capture_c = ~flush & ~stall[4] & ~stall[5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            wd_q          <= 5'd0;
            wreg_q        <= 1'b0;
            wdata_q       <= 32'd0;
            whilo_q       <= 1'b0;
            hi_q          <= 32'd0;
            lo_q          <= 32'd0;
            llbit_we_q    <= 1'b0;
            llbit_value_q <= 1'b0;
        end else if (bubble_c) begin
            valid_q       <= 1'b0;
            wd_q          <= 5'd0;
            wreg_q        <= 1'b0;
            wdata_q       <= 32'd0;
            whilo_q       <= 1'b0;
            hi_q          <= 32'd0;
            lo_q          <= 32'd0;
            llbit_we_q    <= 1'b0;
            llbit_value_q <= 1'b0;
        end else if (capture_c) begin
            // Write enables are qualified so a MEM bubble never commits state.
            valid_q       <= mem.valid;
            wd_q          <= mem.wd;
            wreg_q        <= mem.wreg & mem.valid;
            wdata_q       <= mem.wdata;
            whilo_q       <= mem.whilo & mem.valid;
            hi_q          <= mem.hi;
            lo_q          <= mem.lo;
            llbit_we_q    <= mem.llbit_we & mem.valid;
            llbit_value_q <= mem.llbit_value;
        end
    end

    // Counts only instructions actually entering WB; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (capture_c && mem.valid) begin
            cnt_q <= cnt_q + RETIRE_W'(1);
        end
    end

    assign wb.valid       = valid_q;
    assign wb.wd          = wd_q;
    assign wb.wreg        = wreg_q;
    assign wb.wdata       = wdata_q;
    assign wb.whilo       = whilo_q;
    assign wb.hi          = hi_q;
    assign wb.lo          = lo_q;
    assign wb.llbit_we    = llbit_we_q;
    assign wb.llbit_value = llbit_value_q;
    assign retire_cnt     = cnt_q;

endmodule

// File: tb/tb_mem_wb.sv
// Self-checking bench for mem_wb: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_mem_wb;
    localparam int unsigned RW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic [RW-1:0] retire_cnt;

    mem_wb_if mem ();
    mem_wb_if wb ();

    mem_wb #(.RETIRE_W(RW)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .mem        (mem.slave),
        .wb         (wb.master),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model of the WB-visible slot and the retire count.
    logic        e_valid, e_wreg, e_whilo, e_llwe, e_llval;
    logic [4:0]  e_wd;
    logic [31:0] e_wdata, e_hi, e_lo;
    int          e_cnt;

    task automatic model_clear();
        e_valid = 1'b0; e_wd = 5'd0; e_wreg = 1'b0; e_wdata = 32'd0; e_whilo = 1'b0;
        e_hi = 32'd0; e_lo = 32'd0; e_llwe = 1'b0; e_llval = 1'b0;
    endtask

    // What the next rising edge should do, given the inputs presented now.
    task automatic model_edge();
        bit mem_held = stall[4];
        bit wb_held  = stall[5];
        if (flush || (mem_held && !wb_held)) begin
            model_clear();
        end else if (!mem_held && !wb_held) begin
            e_valid = mem.valid;
            e_wd    = mem.wd;
            e_wdata = mem.wdata;
            e_hi    = mem.hi;
            e_lo    = mem.lo;
            e_llval = mem.llbit_value;
            e_wreg  = mem.valid ? mem.wreg : 1'b0;
            e_whilo = mem.valid ? mem.whilo : 1'b0;
            e_llwe  = mem.valid ? mem.llbit_we : 1'b0;
            if (mem.valid) e_cnt = (e_cnt + 1) % (1 << RW);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},  32'(wb.valid),       32'(e_valid));
        chk({tag, ".wd"},     32'(wb.wd),          32'(e_wd));
        chk({tag, ".wreg"},   32'(wb.wreg),        32'(e_wreg));
        chk({tag, ".wdata"},  wb.wdata,            e_wdata);
        chk({tag, ".whilo"},  32'(wb.whilo),       32'(e_whilo));
        chk({tag, ".hi"},     wb.hi,               e_hi);
        chk({tag, ".lo"},     wb.lo,               e_lo);
        chk({tag, ".llwe"},   32'(wb.llbit_we),    32'(e_llwe));
        chk({tag, ".llval"},  32'(wb.llbit_value), 32'(e_llval));
        chk({tag, ".cnt"},    32'(retire_cnt),     32'(e_cnt));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields();
        mem.wd          = 5'($urandom);
        mem.wreg        = 1'($urandom);
        mem.wdata       = $urandom;
        mem.whilo       = 1'($urandom);
        mem.hi          = $urandom;
        mem.lo          = $urandom;
        mem.llbit_we    = 1'($urandom);
        mem.llbit_value = 1'($urandom);
    endtask

    task automatic set_valid_op(input logic [4:0] wd, input logic [31:0] wdata);
        rand_fields();
        mem.valid = 1'b1;
        mem.wd    = wd;
        mem.wreg  = 1'b1;
        mem.wdata = wdata;
    endtask

    initial begin
        logic [5:0] stall_pick [6];
        stall_pick[0] = 6'b000000; stall_pick[1] = 6'b000000; stall_pick[2] = 6'b111111;
        stall_pick[3] = 6'b011111; stall_pick[4] = 6'b100000; stall_pick[5] = 6'b001111;

        rst = 1'b1; stall = 6'd0; flush = 1'b0;
        mem.valid = 1'b0;
        rand_fields();
        model_clear();
        e_cnt = 0;
        #1;
        check_all("reset_state");

        // Asynchronous reset between edges clears everything without a clock.
        #11 rst = 1'b0;
        set_valid_op(5'd9, 32'h1234_5678);
        tick();
        check_all("pre_reset_cap");
        set_valid_op(5'd17, 32'hCAFE_F00D);
        #3 rst = 1'b1;
        #1;
        model_clear();
        e_cnt = 0;
        check_all("async_reset");
        #2 rst = 1'b0;
        set_valid_op(5'd3, 32'hDEAD_BEEF);
        tick();
        chk("first_cap.wd", 32'(wb.wd), 32'd3);
        chk("first_cap.wreg", 32'(wb.wreg), 32'd1);
        chk("first_cap.wdata", wb.wdata, 32'hDEAD_BEEF);
        chk("first_cap.cnt", 32'(retire_cnt), 32'd1);
        check_all("first_cap");

        // Hold: outputs frozen across three full-stall cycles.
        set_valid_op(5'd4, 32'h1);
        tick();
        check_all("hold_pre");
        stall = 6'b111111;
        mem.wdata = 32'h2;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold.wdata", wb.wdata, 32'h1);
            chk("hold.cnt", 32'(retire_cnt), 32'd2);
        end
        stall = 6'b000000;
        tick();
        chk("hold_release.wdata", wb.wdata, 32'h2);
        check_all("hold_release");

        // Bubble: MEM stalled, WB running.
        set_valid_op(5'd7, 32'hA5A5_0000);
        mem.whilo = 1'b1; mem.llbit_we = 1'b1;
        stall = 6'b011111;
        tick();
        chk("bubble.valid", 32'(wb.valid), 32'd0);
        chk("bubble.wreg", 32'(wb.wreg), 32'd0);
        chk("bubble.cnt", 32'(retire_cnt), 32'd3);
        check_all("bubble");

        // Flush while fully stalled with a live write in WB.
        stall = 6'b000000;
        set_valid_op(5'd8, 32'h5555_AAAA);
        tick();
        chk("flush_pre.wreg", 32'(wb.wreg), 32'd1);
        flush = 1'b1; stall = 6'b111111;
        tick();
        chk("flush.wdata", wb.wdata, 32'd0);
        check_all("flush");
        flush = 1'b0; stall = 6'b000000;

        // Invalid slot: write enables must be suppressed.
        rand_fields();
        mem.valid = 1'b0; mem.wreg = 1'b1; mem.whilo = 1'b1; mem.llbit_we = 1'b1;
        tick();
        chk("invalid.wreg", 32'(wb.wreg), 32'd0);
        chk("invalid.whilo", 32'(wb.whilo), 32'd0);
        chk("invalid.llwe", 32'(wb.llbit_we), 32'd0);
        check_all("invalid");

        // Wrap of a 4-bit counter after 16 captures from reset.
        rst = 1'b1;
        #1;
        model_clear();
        e_cnt = 0;
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            set_valid_op(5'(i), 32'(i) * 32'h0101_0101);
            tick();
            check_all("wrap_step");
            if (i == 15) chk("wrap.cnt15", 32'(retire_cnt), 32'd15);
            if (i == 16) chk("wrap.cnt0", 32'(retire_cnt), 32'd0);
        end

        // Randomized traffic across all stall/flush combinations.
        for (int i = 0; i < 300; i++) begin
            rand_fields();
            mem.valid = ($urandom_range(3) != 0);
            stall = stall_pick[$urandom_range(5)];
            flush = ($urandom_range(7) == 0);
            tick();
            check_all("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
